// File: rtl/d_mem_ctrl_if.sv
// rtl/d_mem_ctrl_if.sv - LSQ memory-request op type and request/response interface
package d_mem_ctrl_pkg;
  typedef enum logic [1:0] {
    no_mem_op = 2'd0,
    mem_read  = 2'd1,
    mem_write = 2'd2
  } memory_op_t;
endpackage

interface d_mem_ctrl_if
  import d_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              lsq_req_valid;
  memory_op_t        lsq_req_op;
  logic [ADDR_W-1:0] lsq_req_address;
  logic [DATA_W-1:0] lsq_req_data;
  logic              mem_ctrl_ready;
  logic              mem_ctrl_done;
  logic [DATA_W-1:0] mem_ctrl_data;
  logic              protocol_err;

  modport master (
    output lsq_req_valid, lsq_req_op, lsq_req_address, lsq_req_data,
    input  mem_ctrl_ready, mem_ctrl_done, mem_ctrl_data, protocol_err
  );

  modport slave (
    input  lsq_req_valid, lsq_req_op, lsq_req_address, lsq_req_data,
    output mem_ctrl_ready, mem_ctrl_done, mem_ctrl_data, protocol_err
  );
endinterface

// File: rtl/d_mem_ctrl.sv
// rtl/d_mem_ctrl.sv - data-memory controller: one LSQ load/store at a time
// against a word-addressed SRAM with fixed ACCESS_LAT cycle latency.
module d_mem_ctrl
  import d_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int ACCESS_LAT = 3
) (
  input logic         clk,
  input logic         reset,
  d_mem_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = (ACCESS_LAT > 2) ? $clog2(ACCESS_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (ACCESS_LAT > 2) ? CNT_W'(ACCESS_LAT - 2) : '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t            r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt, w_next_cnt;
  memory_op_t        r_op;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  logic              w_ready;
  logic              w_accept;
  logic              w_drop;
  logic              w_enter_respond;
  logic              w_done;
  logic [IDX_W-1:0]  w_req_idx;
  logic [IDX_W-1:0]  w_cur_idx;

  assign w_ready   = (r_state == S_IDLE);
  assign w_req_idx = bus.lsq_req_address[IDX_W+1:2];
  assign w_accept  = bus.lsq_req_valid && w_ready && (bus.lsq_req_op != no_mem_op);
  assign w_drop    = bus.lsq_req_valid && (!w_ready || (bus.lsq_req_op == no_mem_op));

  // With ACCESS_LAT==1 the read happens on the accept edge, before r_idx is loaded.
  assign w_cur_idx       = (r_state == S_IDLE) ? w_req_idx : r_idx;
  assign w_enter_respond = (w_next_state == S_RESPOND) && (r_state != S_RESPOND);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (ACCESS_LAT == 1) begin
            w_next_state = S_RESPOND;
          end else begin
            w_next_state = S_ACCESS;
            w_next_cnt   = CNT_LOAD;
          end
        end
      end
      S_ACCESS: begin
        if (r_cnt == '0) begin
          w_next_state = S_RESPOND;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      S_RESPOND: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= no_mem_op;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_op    <= bus.lsq_req_op;
        r_idx   <= w_req_idx;
        r_wdata <= bus.lsq_req_data;
      end
      if (w_enter_respond) begin
        r_rd_data <= r_mem[w_cur_idx];
      end
      if (w_drop) begin
        r_err <= 1'b1;
      end
    end
  end

  // Array is never cleared; a write caught by reset in RESPOND is discarded.
  always_ff @(posedge clk) begin
    if (reset && (r_state == S_RESPOND) && (r_op == mem_write)) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign w_done              = reset && (r_state == S_RESPOND);
  assign bus.mem_ctrl_ready  = w_ready;
  assign bus.mem_ctrl_done   = w_done;
  assign bus.mem_ctrl_data   = (w_done && (r_op == mem_read)) ? r_rd_data : '0;
  assign bus.protocol_err    = r_err;

endmodule

// File: tb/tb_d_mem_ctrl.sv
// tb/tb_d_mem_ctrl.sv - directed self-checking bench for d_mem_ctrl
// (ACCESS_LAT=3 instance plus an ACCESS_LAT=1 instance).
module tb_d_mem_ctrl;
  import d_mem_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  d_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  d_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  d_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .ACCESS_LAT(3)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  d_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .ACCESS_LAT(1)) u_dut_lat1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit sel, input logic v, input memory_op_t op,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      bus1.lsq_req_valid = v; bus1.lsq_req_op = op;
      bus1.lsq_req_address = addr; bus1.lsq_req_data = wdata;
    end else begin
      bus0.lsq_req_valid = v; bus0.lsq_req_op = op;
      bus0.lsq_req_address = addr; bus0.lsq_req_data = wdata;
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? bus1.mem_ctrl_ready : bus0.mem_ctrl_ready;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? bus1.mem_ctrl_done : bus0.mem_ctrl_done;
  endfunction

  function automatic logic [31:0] get_data(input bit sel);
    return sel ? bus1.mem_ctrl_data : bus0.mem_ctrl_data;
  endfunction

  // One request; checks ready before, latency to done, data with done,
  // done width of one cycle and ready again at accept+LAT+1.
  task automatic do_req(input bit sel, input memory_op_t op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, input string tag);
    int lat;
    int n;
    lat = sel ? 1 : 3;
    check_eq({tag, "_rdy_in"}, 32'(get_ready(sel)), 32'd1);
    set_req(sel, 1'b1, op, addr, wdata);
    step();
    set_req(sel, 1'b0, no_mem_op, 32'h0, 32'h0);
    n = 1;
    while (!get_done(sel) && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, "_lat"}, 32'(n), 32'(lat));
    check_eq({tag, "_data"}, get_data(sel), (op == mem_read) ? exp : 32'h0);
    step();
    check_eq({tag, "_done_off"}, 32'(get_done(sel)), 32'd0);
    check_eq({tag, "_rdy_out"}, 32'(get_ready(sel)), 32'd1);
  endtask

  initial begin
    int n;
    n_tests = 0;
    n_fail  = 0;
    set_req(1'b0, 1'b0, no_mem_op, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, no_mem_op, 32'h0, 32'h0);

    // reset
    reset = 1'b0;
    step();
    step();
    check_eq("rst_ready", 32'(bus0.mem_ctrl_ready), 32'd1);
    check_eq("rst_done",  32'(bus0.mem_ctrl_done),  32'd0);
    check_eq("rst_data",  bus0.mem_ctrl_data,       32'h0);
    check_eq("rst_err",   32'(bus0.protocol_err),   32'd0);
    check_eq("rst_ready1", 32'(bus1.mem_ctrl_ready), 32'd1);
    reset = 1'b1;
    step();

    // write then read
    do_req(1'b0, mem_write, 32'h10, 32'hDEADBEEF, 32'h0, "wr10");
    do_req(1'b0, mem_read,  32'h10, 32'h0, 32'hDEADBEEF, "rd10");

    // aliasing: 0x1000 maps to idx 0; byte offset ignored
    do_req(1'b0, mem_write, 32'h1000, 32'h5, 32'h0, "wr1000");
    do_req(1'b0, mem_read,  32'h0,    32'h0, 32'h5, "rd0");
    do_req(1'b0, mem_read,  32'h13,   32'h0, 32'hDEADBEEF, "rd13");
    check_eq("err_clean", 32'(bus0.protocol_err), 32'd0);

    // busy drop
    do_req(1'b0, mem_write, 32'h20, 32'h11, 32'h0, "wr20");
    set_req(1'b0, 1'b1, mem_read, 32'h20, 32'h0);
    step();
    set_req(1'b0, 1'b1, mem_write, 32'h20, 32'h7);
    step();
    set_req(1'b0, 1'b0, no_mem_op, 32'h0, 32'h0);
    check_eq("busy_err", 32'(bus0.protocol_err), 32'd1);
    n = 2;
    while (!bus0.mem_ctrl_done && n < 20) begin
      step();
      n++;
    end
    check_eq("busy_lat",  32'(n), 32'd3);
    check_eq("busy_data", bus0.mem_ctrl_data, 32'h11);
    step();
    do_req(1'b0, mem_read, 32'h20, 32'h0, 32'h11, "rd20_after");

    // reset in RESPOND discards the write and suppresses done
    do_req(1'b0, mem_write, 32'h30, 32'h55, 32'h0, "wr30_old");
    set_req(1'b0, 1'b1, mem_write, 32'h30, 32'hAA);
    step();
    set_req(1'b0, 1'b0, no_mem_op, 32'h0, 32'h0);
    step();
    step();
    reset = 1'b0;
    #1;
    check_eq("midrst_done", 32'(bus0.mem_ctrl_done), 32'd0);
    step();
    reset = 1'b1;
    check_eq("midrst_ready", 32'(bus0.mem_ctrl_ready), 32'd1);
    check_eq("midrst_err",   32'(bus0.protocol_err),   32'd0);
    step();
    check_eq("midrst_nodone", 32'(bus0.mem_ctrl_done), 32'd0);
    do_req(1'b0, mem_read, 32'h30, 32'h0, 32'h55, "rd30_old");

    // no_mem_op request is dropped and flagged
    set_req(1'b0, 1'b1, no_mem_op, 32'h40, 32'h0);
    step();
    set_req(1'b0, 1'b0, no_mem_op, 32'h0, 32'h0);
    check_eq("nop_err",   32'(bus0.protocol_err),   32'd1);
    check_eq("nop_ready", 32'(bus0.mem_ctrl_ready), 32'd1);
    step();
    check_eq("nop_done",  32'(bus0.mem_ctrl_done),  32'd0);

    // ACCESS_LAT=1 instance, back-to-back every 2 cycles
    do_req(1'b1, mem_write, 32'h4, 32'h123, 32'h0, "l1_wr4");
    do_req(1'b1, mem_read,  32'h4, 32'h0, 32'h123, "l1_rd4a");
    do_req(1'b1, mem_write, 32'h8, 32'hCAFE, 32'h0, "l1_wr8");
    do_req(1'b1, mem_read,  32'h8, 32'h0, 32'hCAFE, "l1_rd8");
    do_req(1'b1, mem_read,  32'h4, 32'h0, 32'h123, "l1_rd4b");
    check_eq("l1_err", 32'(bus1.protocol_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
